// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package stream_demux_pkg;

  localparam int unsigned N_OUT = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [SEL_W-1:0] sel_t;

  // Decode a lane select into a one-hot lane vector.
  function automatic logic [N_OUT-1:0] sel_onehot(input sel_t sel);
    logic [N_OUT-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/stream_demux_fifo2.sv
// Two-entry FIFO owned by one demux output lane. Head is driven straight from storage,
// so there is no combinational path from push to head.
module stream_demux_fifo2
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  cnt_t             cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Occupancy decode and guarded push/pop so count can never over- or underflow.
  always_comb begin
    full_o  = (cnt_q == cnt_t'(DEPTH));
    empty_o = (cnt_q == '0);
    head_o  = mem_q[rd_ptr_q];
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    cnt_d   = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + cnt_t'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - cnt_t'(1);
    end
  end

  // Pointer and count state; simultaneous push and pop advances both pointers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Storage; cleared on reset so the lane presents zero data after a flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/stream_demux_1_4.sv
// Buffered 1-to-4 stream demultiplexer: each upstream beat is steered by up_sel into a
// per-lane 2-entry FIFO, so a stalled lane only blocks beats addressed to it.
// Optional macro STREAM_DEMUX_STATS_EN adds saturating per-lane pop counters on stat_count.
module stream_demux_1_4 #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [WIDTH-1:0]   up_data,
  input  logic [1:0]         up_sel,
  output logic [3:0]         down_valid,
  input  logic [3:0]         down_ready,
  output logic [4*WIDTH-1:0] down_data
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [4*8-1:0]     stat_count
`endif
);

  import stream_demux_pkg::*;

  if (DEPTH != stream_demux_pkg::DEPTH) begin : g_depth_check
    $error("stream_demux_1_4: only DEPTH=2 is supported");
  end

  logic [N_OUT-1:0] push, pop, full, empty;
  logic [WIDTH-1:0] head [N_OUT];

  // Ready depends only on registered occupancy of the selected lane (no pop-through).
  // Push is gated by up_valid first so X on up_sel/up_data cannot disturb state.
  always_comb begin
    up_ready   = !full[up_sel];
    push       = '0;
    if (up_valid && up_ready) begin
      push = sel_onehot(sel_t'(up_sel));
    end
    down_valid = ~empty;
    pop        = down_valid & down_ready;
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_lane
    stream_demux_fifo2 #(
      .WIDTH (WIDTH)
    ) u_fifo (
      .clk_i       (clk),
      .rst_i       (rst),
      .push_i      (push[g]),
      .push_data_i (up_data),
      .pop_i       (pop[g]),
      .full_o      (full[g]),
      .empty_o     (empty[g]),
      .head_o      (head[g])
    );

    assign down_data[g*WIDTH +: WIDTH] = head[g];

`ifdef STREAM_DEMUX_STATS_EN
    logic [7:0] stat_q;

    // Saturating count of pops on this lane.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stat_q <= '0;
      end else if (pop[g] && (stat_q != 8'hFF)) begin
        stat_q <= stat_q + 8'd1;
      end
    end

    assign stat_count[g*8 +: 8] = stat_q;
`endif
  end

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed and model-checked bench for stream_demux_1_4.
module tb_stream_demux_1_4;

  typedef logic [3:0] beat_t;

  logic        clk;
  logic        rst;
  logic        up_valid;
  logic        up_ready;
  logic [3:0]  up_data;
  logic [1:0]  up_sel;
  logic [3:0]  down_valid;
  logic [3:0]  down_ready;
  logic [15:0] down_data;
`ifdef STREAM_DEMUX_STATS_EN
  logic [31:0] stat_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  beat_t q [4][$];

  stream_demux_1_4 #(
    .WIDTH (4),
    .DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_sel     (up_sel),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data)
`ifdef STREAM_DEMUX_STATS_EN
    ,
    .stat_count (stat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [1:0] sel, input logic [3:0] data);
    up_valid = 1'b1;
    up_sel   = sel;
    up_data  = data;
    tick();
    up_valid = 1'b0;
  endtask

  initial begin
    logic [3:0]  exp_dv;
    logic        exp_rdy;
    logic [15:0] exp_data, mask;

    rst        = 1'b1;
    up_valid   = 1'b0;
    up_data    = '0;
    up_sel     = '0;
    down_ready = '0;
    tick();
    tick();
    chk("reset_down_valid", 32'(down_valid), 32'h0);
    chk("reset_down_data", 32'(down_data), 32'h0);
    chk("reset_up_ready", 32'(up_ready), 32'h1);

    // Idle with junk on data/select must not create beats.
    rst     = 1'b0;
    up_data = 'x;
    up_sel  = 'x;
    tick();
    tick();
    up_sel  = 2'd0;
    up_data = 4'd0;
    #1;
    chk("idle_x_down_valid", 32'(down_valid), 32'h0);
    chk("idle_x_up_ready", 32'(up_ready), 32'h1);

    // Routing: each beat appears only on its own lane one cycle after acceptance.
    down_ready = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      up_sel = 2'(s);
      #1;
      chk("route_up_ready", 32'(up_ready), 32'h1);
      push_beat(2'(s), 4'(4'hA + s));
      chk("route_down_valid", 32'(down_valid), 32'(4'b0001 << s));
      chk("route_down_data", 32'(down_data[s*4 +: 4]), 32'(4'hA + s));
      tick();
      chk("route_drained", 32'(down_valid), 32'h0);
    end

    // Full lane: two beats fit, third is refused; pops free space one at a time.
    down_ready = 4'b0000;
    push_beat(2'd1, 4'd5);
    push_beat(2'd1, 4'd6);
    up_valid = 1'b1;
    up_sel   = 2'd1;
    up_data  = 4'd7;
    #1;
    chk("full_up_ready", 32'(up_ready), 32'h0);
    chk("full_down_valid", 32'(down_valid), 32'h2);
    chk("full_head", 32'(down_data[7:4]), 32'h5);
    tick();
    up_valid   = 1'b0;
    down_ready = 4'b0010;
    #1;
    chk("full_refused_head", 32'(down_data[7:4]), 32'h5);
    tick();
    chk("full_pop1_up_ready", 32'(up_ready), 32'h1);
    chk("full_pop1_head", 32'(down_data[7:4]), 32'h6);
    chk("full_pop1_valid", 32'(down_valid), 32'h2);
    tick();
    chk("full_pop2_valid", 32'(down_valid), 32'h0);

    // Lane isolation: lane 3 stalled full, lane 0 still accepts.
    down_ready = 4'b0000;
    push_beat(2'd3, 4'd1);
    push_beat(2'd3, 4'd2);
    up_valid = 1'b1;
    up_sel   = 2'd3;
    up_data  = 4'd3;
    #1;
    chk("iso_lane3_up_ready", 32'(up_ready), 32'h0);
    up_sel  = 2'd0;
    up_data = 4'd9;
    #1;
    chk("iso_lane0_up_ready", 32'(up_ready), 32'h1);
    tick();
    up_valid = 1'b0;
    chk("iso_down_valid", 32'(down_valid), 32'h9);
    chk("iso_lane0_data", 32'(down_data[3:0]), 32'h9);
    chk("iso_lane3_data", 32'(down_data[15:12]), 32'h1);
    down_ready = 4'b0001;
    tick();
    chk("iso_after_pop_valid", 32'(down_valid), 32'h8);
    chk("iso_lane3_held", 32'(down_data[15:12]), 32'h1);

    // Same-lane push and pop at count=1.
    down_ready = 4'b0000;
    push_beat(2'd0, 4'd4);
    up_valid   = 1'b1;
    up_sel     = 2'd0;
    up_data    = 4'd8;
    down_ready = 4'b0001;
    #1;
    chk("pp_up_ready", 32'(up_ready), 32'h1);
    chk("pp_head_before", 32'(down_data[3:0]), 32'h4);
    tick();
    up_valid   = 1'b0;
    down_ready = 4'b0000;
    #1;
    chk("pp_valid_after", 32'(down_valid[0]), 32'h1);
    chk("pp_head_after", 32'(down_data[3:0]), 32'h8);
    down_ready = 4'b0001;
    tick();
    chk("pp_single_entry", 32'(down_valid[0]), 32'h0);

    // Mid-stream reset with lane 2 full flushes everything asynchronously.
    down_ready = 4'b0000;
    push_beat(2'd2, 4'd3);
    push_beat(2'd2, 4'd4);
    chk("rst_pre_valid", 32'(down_valid), 32'hC);
    #2;
    rst    = 1'b1;
    up_sel = 2'd2;
    #1;
    chk("rst_async_valid", 32'(down_valid), 32'h0);
    chk("rst_async_data", 32'(down_data), 32'h0);
    chk("rst_async_up_ready", 32'(up_ready), 32'h1);
    tick();
    rst = 1'b0;
    push_beat(2'd2, 4'hE);
    chk("rst_first_beat_valid", 32'(down_valid), 32'h4);
    chk("rst_first_beat_data", 32'(down_data[11:8]), 32'hE);
    down_ready = 4'b0100;
    tick();
    chk("rst_first_beat_drained", 32'(down_valid), 32'h0);

    // Random traffic against a per-lane queue model.
    for (int c = 0; c < 400; c++) begin
      up_valid   = ($urandom_range(0, 9) < 6);
      up_sel     = 2'($urandom);
      up_data    = 4'($urandom);
      down_ready = 4'($urandom);
      #1;
      exp_rdy  = (q[up_sel].size() != 2);
      exp_data = '0;
      mask     = '0;
      for (int i = 0; i < 4; i++) begin
        exp_dv[i] = (q[i].size() != 0);
        if (exp_dv[i]) begin
          exp_data[i*4 +: 4] = q[i][0];
          mask[i*4 +: 4]     = 4'hF;
        end
      end
      chk("rand_up_ready", 32'(up_ready), 32'(exp_rdy));
      chk("rand_down_valid", 32'(down_valid), 32'(exp_dv));
      chk("rand_down_data", 32'(down_data & mask), 32'(exp_data));
      tick();
      for (int i = 0; i < 4; i++) begin
        if (exp_dv[i] && down_ready[i]) void'(q[i].pop_front());
      end
      if (up_valid && exp_rdy) q[up_sel].push_back(up_data);
    end
    up_valid   = 1'b0;
    down_ready = 4'b0000;

`ifdef STREAM_DEMUX_STATS_EN
    // Stream continuously into lane 2: k ticks give k-1 pops.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("stat_reset", stat_count, 32'h0);
    up_valid   = 1'b1;
    up_sel     = 2'd2;
    up_data    = 4'h3;
    down_ready = 4'b0100;
    for (int k = 0; k < 11; k++) tick();
    chk("stat_ten_pops", stat_count, 32'h000A_0000);
    for (int k = 0; k < 299; k++) tick();
    chk("stat_saturated", stat_count, 32'h00FF_0000);
    up_valid   = 1'b0;
    down_ready = 4'b0000;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
